instruction_fetch_unit: RTL and testbench

Instruction fetch stage sitting directly upstream of the IF/ID pipeline register. It owns the 64-bit fetch PC, issues 32-bit instruction reads to instruction memory over a ready/valid handshake, and buffers returned instructions in a 2-entry queue. The queue head is presented to IF/ID as PC_out/Instruction. The unit honours a downstream stall and a branch/jump redirect that flushes all fetched-but-unconsumed instructions.

---
 rtl/instruction_fetch_unit_if.sv | 29 ++
 rtl/instruction_fetch_unit.sv | 168 ++++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory read channel between the fetch unit and instruction memory.
//   imem_req    : read request valid (fetch unit -> memory)
//   imem_addr   : 64-bit read address (fetch unit -> memory)
//   imem_ready  : memory accepts the request this cycle (memory -> fetch unit)
//   imem_rvalid : read data valid, responses return in order (memory -> fetch unit)
//   imem_rdata  : 32-bit instruction word (memory -> fetch unit)
interface instruction_fetch_unit_if;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage feeding the IF/ID pipeline register.
// Owns the 64-bit fetch PC, issues one-at-a-time 32-bit reads over a
// ready/valid channel and buffers returned words in a 2-entry queue whose
// head is presented downstream.
//   clk         : clock, all state updates on posedge
//   reset       : asynchronous active-low reset
//   stall       : IF/ID holding, queue head must not be consumed
//   redirect    : taken branch/jump, flush queue and refetch from redirect_pc
//   redirect_pc : new fetch address, bits [1:0] forced to zero
//   imem        : instruction-memory read channel (master side)
//   fetch_valid : PC_out/Instruction hold a real instruction
//   PC_out      : PC of the head instruction, 0 when not valid
//   Instruction : head instruction, NOP_INSTR when not valid
module instruction_fetch_unit #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            stall,
  input  logic                            redirect,
  input  logic [63:0]                     redirect_pc,
  instruction_fetch_unit_if.master        imem,
  output logic                            fetch_valid,
  output logic [63:0]                     PC_out,
  output logic [31:0]                     Instruction
);

  // Read-channel tracking: BUSY = one read in flight whose data will be
  // queued, DROP = one read in flight whose data belongs to a flushed path.
  typedef enum logic [1:0] {
    RD_IDLE,
    RD_BUSY,
    RD_DROP
  } rd_state_t;

  rd_state_t   rd_state;
  rd_state_t   rd_state_nxt;

  logic [63:0] fetch_pc;
  logic [63:0] req_pc;

  logic [63:0] q_pc    [2];
  logic [31:0] q_instr [2];
  logic        head;
  logic        tail;
  logic [1:0]  count;
  logic [1:0]  count_after;

  logic        outstanding;
  logic        drop;
  logic        rsp;
  logic        pop;
  logic        push;
  logic        handshake;

  logic        unused_redirect_lsb;
  assign unused_redirect_lsb = &{1'b0, redirect_pc[1:0]};

  assign outstanding = (rd_state != RD_IDLE);
  assign drop        = (rd_state == RD_DROP);
  // rvalid with nothing in flight is not a response at all
  assign rsp         = outstanding && imem.imem_rvalid;

  assign fetch_valid = (count != 2'd0);
  assign pop         = fetch_valid && !stall && !redirect;
  assign push        = rsp && !drop && !redirect;
  assign count_after = count + {1'b0, push} - {1'b0, pop};

  assign handshake   = imem.imem_req && imem.imem_ready;
  assign imem.imem_addr = fetch_pc;

  // Tail slot: with one entry it is the slot after head, when empty it is head.
  // A push never lands on a full queue because a request only issues when a
  // slot is guaranteed for its response.
  assign tail = head ^ count[0];

  // ---------------------------------------------------------------------------
  // Read-channel FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_state <= RD_IDLE;
    end else begin
      rd_state <= rd_state_nxt;
    end
  end

  always_comb begin
    rd_state_nxt  = rd_state;
    // The request may issue in the cycle the previous response returns, and
    // is gated on reset so nothing leaves the unit while reset is held.
    imem.imem_req = reset && !redirect &&
                    (!outstanding || imem.imem_rvalid) &&
                    (count_after <= 2'd1);

    if (redirect) begin
      if (rsp) begin
        rd_state_nxt = RD_IDLE;
      end else if (outstanding) begin
        rd_state_nxt = RD_DROP;
      end
    end else if (handshake) begin
      rd_state_nxt = RD_BUSY;
    end else if (rsp) begin
      rd_state_nxt = RD_IDLE;
    end
  end

  // ---------------------------------------------------------------------------
  // Fetch PC and in-flight PC
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
    end else if (redirect) begin
      fetch_pc <= {redirect_pc[63:2], 2'b00};
    end else if (handshake) begin
      req_pc   <= fetch_pc;
      fetch_pc <= fetch_pc + 64'd4;
    end
  end

  // ---------------------------------------------------------------------------
  // Instruction queue
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      head  <= 1'b0;
    end else if (redirect) begin
      count <= '0;
      head  <= 1'b0;
    end else begin
      count <= count_after;
      if (pop) begin
        head <= ~head;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[tail]    <= req_pc;
      q_instr[tail] <= imem.imem_rdata;
    end
  end

  always_comb begin
    PC_out      = '0;
    Instruction = NOP_INSTR;
    if (fetch_valid) begin
      PC_out      = q_pc[head];
      Instruction = q_instr[head];
    end
  end

  // ---------------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------------
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    push |-> (count != 2'd2 || pop));

  a_addr_stable: assert property (@(posedge clk) disable iff (!reset)
    (imem.imem_req && !imem.imem_ready) |=> $stable(imem.imem_addr));

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        fetch_valid;
  logic [63:0] PC_out;
  logic [31:0] Instruction;

  instruction_fetch_unit_if bus ();

  instruction_fetch_unit #(
    .RESET_PC  (64'h0),
    .NOP_INSTR (32'h0000_0013)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem        (bus.master),
    .fetch_valid (fetch_valid),
    .PC_out      (PC_out),
    .Instruction (Instruction)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] exp_q [$];

  // memory-model controls
  int unsigned mem_k    = 1;
  logic        ready_en = 1'b1;
  logic        spur     = 1'b0;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Instruction memory: at most one read tracked, response k cycles after
  // the handshake. Inputs change at negedge+1, handshakes sampled at negedge+2.
  initial begin
    logic        pend;
    logic [63:0] pend_addr;
    int unsigned wait_left;
    pend = 1'b0;
    pend_addr = '0;
    wait_left = 0;
    bus.imem_ready  = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    forever begin
      @(negedge clk);
      #1;
      bus.imem_rvalid = 1'b0;
      if (spur) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hBAD0_BAD0;
      end else if (pend) begin
        wait_left--;
        if (wait_left == 0) begin
          bus.imem_rvalid = 1'b1;
          bus.imem_rdata  = mem_word(pend_addr);
          pend = 1'b0;
        end
      end
      bus.imem_ready = ready_en;
      #1;
      if (bus.imem_req && bus.imem_ready) begin
        pend      = 1'b1;
        pend_addr = bus.imem_addr;
        wait_left = mem_k;
      end
    end
  end

  // Monitor: every instruction consumed by IF/ID is checked against the
  // next expected PC and its memory word.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (reset && fetch_valid && !stall && !redirect) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_instr: got pc %h instr %h expected none", PC_out, Instruction);
        end else begin
          e = exp_q.pop_front();
          check("sb_pc", PC_out, e);
          check("sb_instr", 64'(Instruction), 64'(mem_word(e)));
        end
      end
    end
  end

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1);
  end

  task automatic idle(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  // Let the monitor consume everything expected, then hold stall so nothing
  // further is consumed. Returns at negedge of the first stalled cycle.
  task automatic drain(input int unsigned max_cyc);
    bit done;
    done = 1'b0;
    for (int unsigned n = 0; n < max_cyc && !done; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        stall = 1'b1;
        done  = 1'b1;
      end
    end
    stall = 1'b1;
    check("drain_left", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic push_exp(input logic [63:0] base, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) exp_q.push_back(base + 64'(4 * i));
  endtask

  task automatic check_idle_out(input string name);
    check({name, "_valid"}, 64'(fetch_valid), 64'd0);
    check({name, "_pc"}, PC_out, 64'd0);
    check({name, "_instr"}, 64'(Instruction), 64'(NOP));
  endtask

  initial begin
    reset = 1'b0;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;

    // reset state
    @(negedge clk);
    #2;
    check_idle_out("rst");
    check("rst_req", 64'(bus.imem_req), 64'd0);

    // streaming from RESET_PC, k=1
    @(negedge clk);
    push_exp(64'h0, 8);
    reset = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      if (i != 0) @(negedge clk);
      #2;
      check("p1_req", 64'(bus.imem_req), 64'd1);
      check("p1_addr", bus.imem_addr, 64'(4 * i));
      check("p1_valid", 64'(fetch_valid), 64'(i == 2));
    end
    drain(40);

    // stall held 5 cycles: queue saturates with 0x20, 0x24
    @(negedge clk);
    for (int unsigned i = 0; i < 3; i++) begin
      @(negedge clk);
      #2;
      check("stall_req", 64'(bus.imem_req), 64'd0);
      check("stall_valid", 64'(fetch_valid), 64'd1);
      check("stall_pc", PC_out, 64'h20);
      check("stall_instr", 64'(Instruction), 64'(mem_word(64'h20)));
    end
    @(negedge clk);
    push_exp(64'h20, 8);
    stall = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      if (i != 0) @(negedge clk);
      #2;
      check("release_valid", 64'(fetch_valid), 64'd1);
      check("release_pc", PC_out, 64'h20 + 64'(4 * i));
    end
    drain(40);

    // redirect while a read to 0x10 is outstanding, k=3
    idle(8);
    mem_k = 3;
    @(negedge clk);
    redirect = 1'b1;
    redirect_pc = 64'h10;
    #2;
    check("rd1_req", 64'(bus.imem_req), 64'd0);
    @(negedge clk);
    redirect = 1'b0;
    #2;
    check("rd1_req_new", 64'(bus.imem_req), 64'd1);
    check("rd1_addr_new", bus.imem_addr, 64'h10);
    @(negedge clk);
    redirect = 1'b1;
    redirect_pc = 64'h1002;
    #2;
    check("rd2_req", 64'(bus.imem_req), 64'd0);
    @(negedge clk);
    redirect = 1'b0;
    #2;
    check("rd2_wait_req", 64'(bus.imem_req), 64'd0);
    check("rd2_wait_valid", 64'(fetch_valid), 64'd0);
    @(negedge clk);
    push_exp(64'h1000, 3);
    stall = 1'b0;
    #2;
    check("rd2_stale_req", 64'(bus.imem_req), 64'd1);
    check("rd2_stale_addr", bus.imem_addr, 64'h1000);
    drain(60);

    // redirect coinciding with rvalid that would fill the queue, k=1
    idle(8);
    mem_k = 1;
    @(negedge clk);
    redirect = 1'b1;
    redirect_pc = 64'h300;
    @(negedge clk);
    redirect = 1'b0;
    #2;
    check("rv_addr0", bus.imem_addr, 64'h300);
    @(negedge clk);
    #2;
    check("rv_addr1", bus.imem_addr, 64'h304);
    @(negedge clk);
    redirect = 1'b1;
    redirect_pc = 64'h2000;
    #2;
    check("rv_head_pc", PC_out, 64'h300);
    check("rv_req", 64'(bus.imem_req), 64'd0);
    @(negedge clk);
    redirect = 1'b0;
    stall = 1'b0;
    push_exp(64'h2000, 3);
    #2;
    check("rv_flush_valid", 64'(fetch_valid), 64'd0);
    check("rv_new_req", 64'(bus.imem_req), 64'd1);
    check("rv_new_addr", bus.imem_addr, 64'h2000);
    @(negedge clk);
    #2;
    check("rv_nobypass_valid", 64'(fetch_valid), 64'd0);
    drain(40);

    // imem_ready low for 4 cycles
    idle(8);
    @(negedge clk);
    ready_en = 1'b0;
    redirect = 1'b1;
    redirect_pc = 64'h4000;
    for (int unsigned i = 0; i < 4; i++) begin
      @(negedge clk);
      redirect = 1'b0;
      #2;
      check("nr_req", 64'(bus.imem_req), 64'd1);
      check("nr_addr", bus.imem_addr, 64'h4000);
      check_idle_out("nr");
    end
    @(negedge clk);
    ready_en = 1'b1;
    stall = 1'b0;
    push_exp(64'h4000, 3);
    drain(40);

    // reset mid-outstanding, late response and spurious rvalid ignored
    idle(8);
    mem_k = 3;
    @(negedge clk);
    redirect = 1'b1;
    redirect_pc = 64'h5000;
    @(negedge clk);
    redirect = 1'b0;
    #2;
    check("mr_addr", bus.imem_addr, 64'h5000);
    for (int unsigned i = 0; i < 4; i++) begin
      @(negedge clk);
      reset = 1'b0;
      #2;
      check_idle_out("mr_rst");
      check("mr_rst_req", 64'(bus.imem_req), 64'd0);
    end
    @(negedge clk);
    reset = 1'b1;
    ready_en = 1'b0;
    spur = 1'b1;
    #2;
    check("mr_rel_req", 64'(bus.imem_req), 64'd1);
    check("mr_rel_addr", bus.imem_addr, 64'h0);
    @(negedge clk);
    ready_en = 1'b1;
    spur = 1'b0;
    stall = 1'b0;
    push_exp(64'h0, 3);
    #2;
    check("mr_spur_valid", 64'(fetch_valid), 64'd0);
    check("mr_addr_after", bus.imem_addr, 64'h0);
    drain(60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
